grid_matrix_scanner: RTL and testbench

- Consumer end of the 64-bit grid stream produced by the seed/evolve pipeline; drives an 8x8 LED matrix.
- Accepts a grid over a valid/ready handshake into a shadow buffer.
- Swaps the shadow buffer into the active buffer only at frame boundaries (tear-free).
- Row-scans the active buffer: serially shifts each row's 8 column bits to an external column shift register, latches them, then enables that row for a fixed dwell.

---
 rtl/grid_matrix_scanner.sv | 142 ++++++++++++++
 tb/tb_grid_matrix_scanner.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_matrix_scanner.sv
// grid_matrix_scanner: takes 64-bit grids over valid/ready into a shadow buffer
// and row-scans an 8x8 LED matrix through an external column shift register.
module grid_matrix_scanner #(
   parameter int SCLK_DIV       = 4,
   parameter int DWELL_CYCLES   = 1000,
   parameter bit ROW_ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] grid,
   input  logic        grid_valid,
   output logic        grid_ready,
   output logic        sclk,
   output logic        sdata,
   output logic        slatch,
   output logic [7:0]  row_en,
   output logic        frame_done,
   output logic        busy
);
   // state   | meaning
   // S_IDLE  | no frame received yet, all outputs inactive
   // S_SHIFT | rows blanked, current row's 8 column bits shifted MSB first
   // S_LATCH | one-cycle column latch pulse
   // S_DWELL | current row enabled for DWELL_CYCLES
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_LATCH = 2'd2;
   localparam logic [1:0] S_DWELL = 2'd3;

   localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DIV_W-1:0]   DIV_LOAD   = DIV_W'(SCLK_DIV - 1);
   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

   logic [1:0]         state;
   logic [2:0]         row;
   logic [2:0]         bit_idx;
   logic [DIV_W-1:0]   div_cnt;
   logic [DWELL_W-1:0] dwell_cnt;
   logic               sclk_phase;
   logic               pending;
   logic [63:0]        shadow;
   logic [63:0]        active;
   logic               accept;
   logic               frame_wrap;
   logic               enter_row0;
   logic [7:0]         row_onehot;

   assign grid_ready = !pending;
   assign accept     = grid_valid && !pending;
   assign frame_wrap = (state == S_DWELL) && (dwell_cnt == '0) && (row == 3'd7);
   assign enter_row0 = ((state == S_IDLE) && pending) || frame_wrap;
   assign busy       = (state != S_IDLE);

   // Accept and swap are mutually exclusive: accept needs pending=0, swap needs pending=1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= 1'b0;
         shadow  <= '0;
         active  <= '0;
      end else if (accept) begin
         shadow  <= grid;
         pending <= 1'b1;
      end else if (enter_row0 && pending) begin
         active  <= shadow;
         pending <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         row        <= 3'd0;
         bit_idx    <= 3'd0;
         div_cnt    <= '0;
         dwell_cnt  <= '0;
         sclk_phase <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_wrap;
         case (state)
            S_IDLE: begin
               if (pending) begin
                  state      <= S_SHIFT;
                  row        <= 3'd0;
                  bit_idx    <= 3'd7;
                  div_cnt    <= DIV_LOAD;
                  sclk_phase <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (div_cnt == '0) begin
                  div_cnt    <= DIV_LOAD;
                  sclk_phase <= ~sclk_phase;
                  if (sclk_phase) begin
                     bit_idx <= bit_idx - 3'd1;
                     if (bit_idx == 3'd0) state <= S_LATCH;
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            S_LATCH: begin
               state     <= S_DWELL;
               dwell_cnt <= DWELL_LOAD;
            end
            S_DWELL: begin
               if (dwell_cnt == '0) begin
                  state      <= S_SHIFT;
                  row        <= row + 3'd1;
                  bit_idx    <= 3'd7;
                  div_cnt    <= DIV_LOAD;
                  sclk_phase <= 1'b0;
               end else begin
                  dwell_cnt <= dwell_cnt - DWELL_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so they go inactive the moment reset hits.
   always_comb begin
      sclk       = 1'b0;
      sdata      = 1'b0;
      slatch     = 1'b0;
      row_onehot = 8'h00;
      case (state)
         S_SHIFT: begin
            sclk  = sclk_phase;
            sdata = active[{row, bit_idx}];
         end
         S_LATCH: slatch = 1'b1;
         S_DWELL: row_onehot = 8'h01 << row;
         default: ;
      endcase
   end

   assign row_en = ROW_ACTIVE_LOW ? ~row_onehot : row_onehot;

endmodule

// File: tb/tb_grid_matrix_scanner.sv
// Bench for grid_matrix_scanner: table vectors, hand sequences and a random
// run checked every cycle against a frame-timing reference model.
module tb_grid_matrix_scanner;
   localparam int SCLK_DIV = 1;
   localparam int DWELL    = 4;
   localparam int SHIFT_P  = 16 * SCLK_DIV;
   localparam int ROW_P    = SHIFT_P + 1 + DWELL;
   localparam int FRAME_P  = 8 * ROW_P;
   localparam logic [13:0] RESET_OUTS = 14'h2000;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] grid;
   logic        grid_valid;
   logic        grid_ready, sclk, sdata, slatch, frame_done, busy;
   logic [7:0]  row_en;
   logic [13:0] outs;

   assign outs = {grid_ready, busy, sclk, sdata, slatch, frame_done, row_en};

   grid_matrix_scanner #(
      .SCLK_DIV(SCLK_DIV),
      .DWELL_CYCLES(DWELL),
      .ROW_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .grid(grid),
      .grid_valid(grid_valid),
      .grid_ready(grid_ready),
      .sclk(sclk),
      .sdata(sdata),
      .slatch(slatch),
      .row_en(row_en),
      .frame_done(frame_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: scan position as a cycle offset since the first SHIFT cycle.
   logic        m_started, m_pending;
   logic [63:0] m_shadow, m_active;
   int          m_k;

   task automatic model_reset();
      m_started = 1'b0;
      m_pending = 1'b0;
      m_shadow  = '0;
      m_active  = '0;
      m_k       = 0;
   endtask

   task automatic model_step(input logic [63:0] g, input logic v);
      logic acc;
      acc = v && !m_pending;
      if (!m_started) begin
         if (m_pending) begin
            m_started = 1'b1;
            m_k       = 0;
            m_active  = m_shadow;
            m_pending = 1'b0;
         end else if (acc) begin
            m_shadow  = g;
            m_pending = 1'b1;
         end
      end else begin
         m_k++;
         if (acc) begin
            m_shadow  = g;
            m_pending = 1'b1;
         end else if (m_pending && (m_k % FRAME_P == 0)) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
         end
      end
   endtask

   function automatic logic [13:0] model_out();
      int r, p;
      logic sc, sd, sl, fd;
      logic [7:0] re;
      sc = 0; sd = 0; sl = 0; fd = 0; re = 8'h00;
      if (m_started) begin
         r = (m_k / ROW_P) % 8;
         p = m_k % ROW_P;
         if (p < SHIFT_P) begin
            sc = ((p / SCLK_DIV) % 2) == 1;
            sd = m_active[8 * r + 7 - p / (2 * SCLK_DIV)];
         end else if (p == SHIFT_P) begin
            sl = 1'b1;
         end else begin
            re = 8'h01 << r;
         end
         fd = (m_k > 0) && (m_k % FRAME_P == 0);
      end
      return {!m_pending, m_started, sc, sd, sl, fd, re};
   endfunction

   // Observer: reconstructs what the matrix would show, independent of the model.
   logic       prev_sclk;
   logic [7:0] prev_row_en;
   logic [7:0] cap;
   int         rises, latches, overlap, first_row, cur_r;
   logic       counting;
   logic [7:0] obs_seen;
   logic [7:0] obs_byte[8];
   int         obs_rise[8], obs_latch[8], obs_dwell[8];
   int         fd_q[$];

   function automatic int onehot_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v == (8'h01 << i)) return i;
      return -1;
   endfunction

   task automatic obs_clear();
      cap = 8'h00; rises = 0; latches = 0; overlap = 0;
      first_row = -1; cur_r = 0; counting = 1'b0; obs_seen = 8'h00;
      fd_q.delete();
      for (int r = 0; r < 8; r++) begin
         obs_byte[r] = 8'h00; obs_rise[r] = 0; obs_latch[r] = 0; obs_dwell[r] = 0;
      end
   endtask

   task automatic observe();
      int r;
      if (row_en == 8'h00) counting = 1'b0;
      if (sclk && !prev_sclk) begin
         cap = {cap[6:0], sdata};
         rises++;
      end
      if (slatch) latches++;
      if (row_en != 8'h00 && (sclk || slatch)) overlap++;
      if (row_en != 8'h00 && prev_row_en == 8'h00) begin
         r = onehot_idx(row_en);
         if (first_row < 0) first_row = r;
         counting = 1'b0;
         if (r >= 0) begin
            if (!obs_seen[r]) begin
               counting     = 1'b1;
               cur_r        = r;
               obs_seen[r]  = 1'b1;
               obs_byte[r]  = cap;
               obs_rise[r]  = rises;
               obs_latch[r] = latches;
            end
         end
         cap = 8'h00; rises = 0; latches = 0;
      end
      if (counting && row_en == (8'h01 << cur_r)) obs_dwell[cur_r]++;
      if (frame_done) fd_q.push_back(cyc);
      prev_sclk   = sclk;
      prev_row_en = row_en;
   endtask

   task automatic tick(input logic [63:0] g, input logic v);
      grid       = g;
      grid_valid = v;
      model_step(g, v);
      @(negedge clk);
      cyc++;
      check("outputs", {50'd0, outs}, {50'd0, model_out()});
      observe();
   endtask

   task automatic apply_reset();
      reset      = 1'b0;
      grid_valid = 1'b0;
      #1;
      check("reset_outputs", {50'd0, outs}, {50'd0, RESET_OUTS});
      model_reset();
      prev_sclk   = 1'b0;
      prev_row_en = 8'h00;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_fd(input logic [63:0] g, input logic v, input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         tick(g, v);
         got = frame_done;
      end
      check("frame_done_seen", {63'd0, got}, 64'd1);
   endtask

   typedef struct {
      logic [63:0] g;
      logic [7:0]  row0;
      logic [7:0]  row7;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ga, gb, gc;
      int c_acc;
      vecs[0] = '{64'h8000_0000_0000_0001, 8'h01, 8'h80};
      vecs[1] = '{64'h0123_4567_89AB_CDEF, 8'hEF, 8'h01};
      vecs[2] = '{64'hFF00_0000_0000_00A5, 8'hA5, 8'hFF};
      vecs[3] = '{64'h5A00_0000_0000_0080, 8'h80, 8'h5A};
      ga = 64'h1122_3344_5566_7788;
      gb = 64'hA5A5_0F0F_F0F0_5A5A;
      gc = 64'h0F1E_2D3C_4B5A_6978;

      // Reset held with a valid grid offered: nothing may move.
      reset = 1'b1; grid_valid = 1'b1; grid = ga;
      model_reset();
      prev_sclk = 1'b0; prev_row_en = 8'h00;
      #2 reset = 1'b0;
      #1 check("reset_outputs", {50'd0, outs}, {50'd0, RESET_OUTS});
      repeat (5) begin
         @(negedge clk);
         check("reset_hold", {50'd0, outs}, {50'd0, RESET_OUTS});
      end
      reset = 1'b1;
      obs_clear();
      repeat (50) tick(64'h0, 1'b0);

      // Table vectors: one full frame per grid.
      for (int i = 0; i < 4; i++) begin
         apply_reset();
         tick(vecs[i].g, 1'b1);
         obs_clear();
         repeat (FRAME_P + 2) tick(64'h0, 1'b0);
         check("row0_bits", {56'd0, obs_byte[0]}, {56'd0, vecs[i].row0});
         check("row7_bits", {56'd0, obs_byte[7]}, {56'd0, vecs[i].row7});
         for (int r = 0; r < 8; r++) begin
            check("row_bits", {56'd0, obs_byte[r]}, {56'd0, vecs[i].g[8*r +: 8]});
            check("sclk_rises", 64'(obs_rise[r]), 64'd8);
            check("latch_pulses", 64'(obs_latch[r]), 64'd1);
            check("dwell_len", 64'(obs_dwell[r]), 64'(DWELL));
         end
         check("row_en_during_shift", 64'(overlap), 64'd0);
      end

      // Frame period with no new grid: the frame repeats.
      apply_reset();
      tick(ga, 1'b1);
      c_acc = cyc;
      obs_clear();
      repeat (3 * FRAME_P + 5) tick(64'h0, 1'b0);
      check("frame_done_count", 64'(fd_q.size()), 64'd3);
      if (fd_q.size() >= 3) begin
         check("first_frame_done", 64'(fd_q[0] - c_acc), 64'(FRAME_P + 1));
         check("frame_period_1", 64'(fd_q[1] - fd_q[0]), 64'(FRAME_P));
         check("frame_period_2", 64'(fd_q[2] - fd_q[1]), 64'(FRAME_P));
      end

      // Tear-free swap: B offered mid-frame, A's frame completes first.
      apply_reset();
      tick(ga, 1'b1);
      repeat (3 * ROW_P + 5) tick(64'h0, 1'b0);
      check("b_ready_before", {63'd0, grid_ready}, 64'd1);
      tick(gb, 1'b1);
      check("b_ready_after", {63'd0, grid_ready}, 64'd0);
      obs_clear();
      wait_fd(gb, 1'b1, FRAME_P + 10);
      for (int r = 4; r < 8; r++)
         check("old_frame_row", {56'd0, obs_byte[r]}, {56'd0, ga[8*r +: 8]});
      obs_clear();
      repeat (FRAME_P) tick(64'h0, 1'b0);
      for (int r = 0; r < 8; r++)
         check("new_frame_row", {56'd0, obs_byte[r]}, {56'd0, gb[8*r +: 8]});
      check("new_frame_first_row", 64'(first_row), 64'd0);

      // Reset in the middle of row 3 shifting, with a grid still pending.
      apply_reset();
      tick(ga, 1'b1);
      repeat (3 * ROW_P + 4) tick(64'h0, 1'b0);
      tick(gb, 1'b1);
      #2 reset = 1'b0;
      #1 check("midrow_reset", {50'd0, outs}, {50'd0, RESET_OUTS});
      model_reset();
      prev_sclk = 1'b0; prev_row_en = 8'h00;
      @(negedge clk);
      check("midrow_reset_hold", {50'd0, outs}, {50'd0, RESET_OUTS});
      reset = 1'b1;
      repeat (20) tick(64'h0, 1'b0);
      tick(gc, 1'b1);
      obs_clear();
      repeat (FRAME_P + 2) tick(64'h0, 1'b0);
      check("restart_first_row", 64'(first_row), 64'd0);
      check("restart_row0", {56'd0, obs_byte[0]}, {56'd0, gc[7:0]});

      // Random traffic against the reference model.
      apply_reset();
      for (int i = 0; i < 4000; i++) begin
         logic v;
         v = ($urandom_range(0, 99) < 4);
         tick({$urandom, $urandom}, v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
